// File: rtl/fir_input_sequencer.sv
// Front end for the FIR core: synchronizes the external strobe/config pins,
// frames coefficient loads and streams samples with an inactivity timeout.
module fir_input_sequencer #(
  parameter int X_N_SIZE       = 8,
  parameter int NBR_OF_TAPS    = 21,
  parameter int COEFS_PER_WORD = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int WAIT_CYCLES    = 4,
  parameter int IDLE_TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] ui_data,
  input  logic                ui_sample_stb,
  input  logic                ui_cfg_req,
  output logic [X_N_SIZE-1:0] x_n,
  output logic                s_axis_fir_tvalid,
  output logic                s_set_coeffs,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                sample_drop
);

  localparam int COEF_WORDS = (NBR_OF_TAPS + COEFS_PER_WORD - 1) / COEFS_PER_WORD;
  localparam int WCW        = $clog2(COEF_WORDS + 1);
  localparam int WAW        = $clog2(WAIT_CYCLES + 1);
  localparam logic [WCW-1:0] COEF_LAST = WCW'(COEF_WORDS - 1);
  localparam logic [WAW-1:0] WAIT_LAST = WAW'(WAIT_CYCLES - 1);
  localparam logic [7:0]     TO_LIMIT  = 8'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_LOAD, S_STREAM} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic [SYNC_STAGES-1:0] r_cfg_sync;
  logic                   r_stb_d;
  logic [WAW-1:0]         r_wait_cnt;
  logic [WCW-1:0]         r_word_cnt;
  logic [7:0]             r_tcnt;
  logic [X_N_SIZE-1:0]    r_x_n;
  logic                   r_tvalid;
  logic                   r_set_coeffs;
  logic                   r_cfg_done;
  logic                   r_sample_drop;

  logic w_stb_s;
  logic w_cfg_s;
  logic w_stb_edge;
  logic w_emit_smp;
  logic w_emit_coef;
  logic w_drop_set;
  logic w_load_start;
  logic w_done_set;

  assign w_stb_s    = r_stb_sync[SYNC_STAGES-1];
  assign w_cfg_s    = r_cfg_sync[SYNC_STAGES-1];
  assign w_stb_edge = w_stb_s & ~r_stb_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stb_sync <= '0;
      r_cfg_sync <= '0;
      r_stb_d    <= 1'b0;
    end else begin
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], ui_sample_stb};
      r_cfg_sync <= {r_cfg_sync[SYNC_STAGES-2:0], ui_cfg_req};
      r_stb_d    <= w_stb_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_WAIT;
    else        r_state <= w_state_nxt;
  end

  // A config request wins over a simultaneous strobe in IDLE; in STREAM the strobe is still emitted.
  always_comb begin
    w_state_nxt  = r_state;
    w_emit_smp   = 1'b0;
    w_emit_coef  = 1'b0;
    w_drop_set   = 1'b0;
    w_load_start = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) w_state_nxt = S_IDLE;
        if (w_stb_edge)              w_drop_set  = 1'b1;
      end
      S_IDLE: begin
        if (w_cfg_s) begin
          w_state_nxt  = S_LOAD;
          w_load_start = 1'b1;
        end else if (w_stb_edge) begin
          w_state_nxt = S_STREAM;
          w_emit_smp  = 1'b1;
        end
      end
      S_LOAD: begin
        if (!w_cfg_s) begin
          w_state_nxt = S_IDLE;
        end else if (w_stb_edge) begin
          w_emit_coef = 1'b1;
          if (r_word_cnt == COEF_LAST) begin
            w_done_set  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_STREAM: begin
        w_emit_smp = w_stb_edge;
        if (w_cfg_s) begin
          w_state_nxt  = S_LOAD;
          w_load_start = 1'b1;
        end else if (!w_stb_edge && (r_tcnt == TO_LIMIT)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt    <= '0;
      r_word_cnt    <= '0;
      r_tcnt        <= '0;
      r_x_n         <= '0;
      r_tvalid      <= 1'b0;
      r_set_coeffs  <= 1'b0;
      r_cfg_done    <= 1'b0;
      r_sample_drop <= 1'b0;
    end else begin
      r_tvalid     <= w_emit_smp;
      r_set_coeffs <= w_emit_coef;
      if (w_emit_smp || w_emit_coef) r_x_n <= ui_data;
      if ((r_state == S_WAIT) && (r_wait_cnt != WAIT_LAST)) r_wait_cnt <= r_wait_cnt + WAW'(1);
      if (w_load_start)     r_word_cnt <= '0;
      else if (w_emit_coef) r_word_cnt <= r_word_cnt + WCW'(1);
      // Timeout counter saturates instead of wrapping.
      if (w_emit_smp) r_tcnt <= '0;
      else if ((r_state == S_STREAM) && (r_tcnt != 8'hFF)) r_tcnt <= r_tcnt + 8'd1;
      if (w_load_start)    r_cfg_done <= 1'b0;
      else if (w_done_set) r_cfg_done <= 1'b1;
      if (w_load_start)    r_sample_drop <= 1'b0;
      else if (w_drop_set) r_sample_drop <= 1'b1;
    end
  end

  assign x_n               = r_x_n;
  assign s_axis_fir_tvalid = r_tvalid;
  assign s_set_coeffs      = r_set_coeffs;
  assign cfg_busy          = (r_state == S_LOAD);
  assign cfg_done          = r_cfg_done;
  assign sample_drop       = r_sample_drop;

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Self-checking bench for fir_input_sequencer: table-driven strobes feed a
// scoreboard of expected pulses (kind, byte, cycle) checked on the falling edge.
module tb_fir_input_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ui_data = 8'h00;
  logic       ui_sample_stb = 1'b0;
  logic       ui_cfg_req = 1'b0;
  logic [7:0] x_n;
  logic       s_axis_fir_tvalid;
  logic       s_set_coeffs;
  logic       cfg_busy;
  logic       cfg_done;
  logic       sample_drop;

  fir_input_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .ui_data           (ui_data),
    .ui_sample_stb     (ui_sample_stb),
    .ui_cfg_req        (ui_cfg_req),
    .x_n               (x_n),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .s_set_coeffs      (s_set_coeffs),
    .cfg_busy          (cfg_busy),
    .cfg_done          (cfg_done),
    .sample_drop       (sample_drop)
  );

  always #5 clk = ~clk;

  localparam int K_SMP  = 1;
  localparam int K_COEF = 2;

  typedef struct { logic [7:0] data; int kind; } vec_t;
  typedef struct { int kind; logic [7:0] data; int cyc; } exp_t;

  vec_t load_tab[7];
  vec_t stream_tab[3];
  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outs_zero(input string pfx);
    chk({pfx, "_xn"}, x_n, 0);
    chk({pfx, "_tvalid"}, s_axis_fir_tvalid, 0);
    chk({pfx, "_set"}, s_set_coeffs, 0);
    chk({pfx, "_busy"}, cfg_busy, 0);
    chk({pfx, "_done"}, cfg_done, 0);
    chk({pfx, "_drop"}, sample_drop, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ui_sample_stb = 1'b0;
    ui_cfg_req = 1'b0;
    ui_data = 8'h00;
    #1;
    chk_outs_zero("rst");
    cycles(3);
    reset = 1'b1;
  endtask

  task automatic stb_rise(input logic [7:0] d, input int kind);
    exp_t e;
    ui_data = d;
    ui_sample_stb = 1'b1;
    if (kind != 0) begin
      e.kind = kind;
      e.data = d;
      e.cyc  = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input int kind, input int hi, input int lo);
    stb_rise(d, kind);
    cycles(hi);
    ui_sample_stb = 1'b0;
    cycles(lo);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (s_axis_fir_tvalid || s_set_coeffs) begin
      chk("pulse_exclusive", s_axis_fir_tvalid & s_set_coeffs, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=tvalid:%0b set:%0b x_n:%0h required=no pulse (t=%0t)",
                 s_axis_fir_tvalid, s_set_coeffs, x_n, $time);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", s_set_coeffs ? K_COEF : K_SMP, e.kind);
        chk("pulse_xn", x_n, e.data);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    load_tab[0] = '{8'h15, K_COEF};
    load_tab[1] = '{8'h2A, K_COEF};
    load_tab[2] = '{8'h3F, K_COEF};
    load_tab[3] = '{8'h00, K_COEF};
    load_tab[4] = '{8'h01, K_COEF};
    load_tab[5] = '{8'h02, K_COEF};
    load_tab[6] = '{8'h03, K_COEF};
    stream_tab[0] = '{8'h7F, K_SMP};
    stream_tab[1] = '{8'h80, K_SMP};
    stream_tab[2] = '{8'h01, K_SMP};

    #2;
    // Quiet power-up: everything stays at zero.
    do_reset();
    cycles(8);
    chk_outs_zero("quiet");

    // Strobe seen on the first IDLE cycle (5th edge after release) is streamed.
    do_reset();
    cycles(2);
    strobe(8'hC3, K_SMP, 4, 4);
    chk("idle_edge_drop", sample_drop, 0);
    chk("idle_edge_q", sb.size(), 0);

    // Strobe seen on the last WAIT cycle is dropped.
    do_reset();
    cycles(1);
    strobe(8'h11, 0, 4, 4);
    chk("wait_drop", sample_drop, 1);
    chk("wait_drop_xn", x_n, 0);

    // Config request clears the drop flag and enters LOAD.
    ui_cfg_req = 1'b1;
    cycles(4);
    chk("cfg_drop_clr", sample_drop, 0);
    chk("cfg_busy", cfg_busy, 1);
    chk("cfg_done_pre", cfg_done, 0);

    // Full load; the request is released one cycle after the last strobe rises.
    for (int i = 0; i < 7; i++) begin
      stb_rise(load_tab[i].data, load_tab[i].kind);
      if (i == 6) begin
        cycles(1);
        ui_cfg_req = 1'b0;
        cycles(3);
      end else begin
        cycles(4);
        chk("load_busy", cfg_busy, 1);
        chk("load_done_mid", cfg_done, 0);
      end
      ui_sample_stb = 1'b0;
      cycles(4);
    end
    chk("load_done", cfg_done, 1);
    chk("load_busy_fall", cfg_busy, 0);
    chk("load_xn_hold", x_n, 8'h03);
    chk("load_q", sb.size(), 0);

    // Aborted load after four bytes.
    ui_cfg_req = 1'b1;
    cycles(4);
    chk("abort_done_clr", cfg_done, 0);
    chk("abort_busy", cfg_busy, 1);
    for (int i = 0; i < 4; i++) strobe(load_tab[i].data, load_tab[i].kind, 4, 4);
    ui_cfg_req = 1'b0;
    cycles(4);
    chk("abort_busy_fall", cfg_busy, 0);
    chk("abort_done", cfg_done, 0);
    strobe(8'h66, K_SMP, 4, 4);
    chk("abort_q", sb.size(), 0);

    // Streaming at 10-cycle spacing, then timeout and re-entry.
    for (int i = 0; i < 3; i++) strobe(stream_tab[i].data, stream_tab[i].kind, 5, 5);
    chk("stream_xn_hold", x_n, 8'h01);
    chk("stream_q", sb.size(), 0);
    cycles(300);
    strobe(8'h5A, K_SMP, 5, 5);
    chk("reentry_q", sb.size(), 0);
    cycles(300);

    // Config request and strobe land together from IDLE: LOAD wins, edge discarded silently.
    ui_cfg_req = 1'b1;
    stb_rise(8'hA5, 0);
    cycles(4);
    chk("simul_busy", cfg_busy, 1);
    chk("simul_drop", sample_drop, 0);
    ui_sample_stb = 1'b0;
    cycles(4);
    chk("simul_busy_hold", cfg_busy, 1);
    chk("simul_xn_hold", x_n, 8'h5A);

    // Reset in the middle of LOAD clears all outputs at once.
    do_reset();
    cycles(8);
    chk_outs_zero("post_abort");
    chk("final_q", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
